pio_edge_in: RTL and testbench



---
 rtl/pio_pkg.sv | 14 +
 rtl/pio_debounce_bit.sv | 52 +++++
 rtl/pio_edge_in.sv | 78 +++++++
 tb/tb_pio_edge_in.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/pio_pkg.sv
// rtl/pio_pkg.sv - shared register map and edge-type encoding for PIO slaves
package pio_pkg;

    localparam logic [1:0] PIO_ADDR_DATA    = 2'd0;
    localparam logic [1:0] PIO_ADDR_IRQMASK = 2'd1;
    localparam logic [1:0] PIO_ADDR_EDGECAP = 2'd2;

    typedef enum logic [1:0] {
        RISE = 2'd0,
        FALL = 2'd1,
        ANY  = 2'd2
    } pio_edge_e;

endpackage

// File: rtl/pio_debounce_bit.sv
// rtl/pio_debounce_bit.sv - one-pin synchronizer and debouncer with change events
module pio_debounce_bit #(
    parameter int   DEBOUNCE_CYCLES = 4,
    parameter logic RESET_LEVEL     = 1'b1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic pin,
    output logic level,
    output logic update,
    output logic rise,
    output logic fall
);

    localparam int              CW       = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1;
    logic          sync2;
    logic          stable;
    logic [CW-1:0] cnt;
    logic          expire;

    // The event is combinational so the top can capture it on the same edge that moves stable.
    assign expire = (sync2 != stable) && (cnt == CNT_LAST);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync1  <= RESET_LEVEL;
            sync2  <= RESET_LEVEL;
            stable <= RESET_LEVEL;
            cnt    <= '0;
        end else begin
            sync1 <= pin;
            sync2 <= sync1;
            if (sync2 == stable) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                stable <= sync2;
                cnt    <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign level  = stable;
    assign update = expire;
    assign rise   = expire & sync2;
    assign fall   = expire & ~sync2;

endmodule

// File: rtl/pio_edge_in.sv
// rtl/pio_edge_in.sv - debounced edge-capturing input PIO slave with maskable irq
module pio_edge_in
    import pio_pkg::*;
#(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int EDGE_TYPE       = 2,
    parameter int RESET_LEVEL     = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [WIDTH-1:0] writedata,
    output logic [WIDTH-1:0] readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);

    localparam pio_edge_e EDGE_SEL = pio_edge_e'(2'(EDGE_TYPE));

    logic [WIDTH-1:0] data;
    logic [WIDTH-1:0] update;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic [WIDTH-1:0] qual;
    logic [WIDTH-1:0] clr;
    logic [WIDTH-1:0] irq_mask;
    logic [WIDTH-1:0] edge_cap;
    logic             wr_en;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        pio_debounce_bit #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .RESET_LEVEL    (RESET_LEVEL != 0)
        ) u_db (
            .clk    (clk),
            .reset_n(reset_n),
            .pin    (in_port[i]),
            .level  (data[i]),
            .update (update[i]),
            .rise   (rise[i]),
            .fall   (fall[i])
        );
    end

    assign qual  = (EDGE_SEL == RISE) ? rise :
                   (EDGE_SEL == FALL) ? fall : update;
    assign wr_en = chipselect && !write_n;
    assign clr   = (wr_en && address == PIO_ADDR_EDGECAP) ? writedata : '0;

    // A new edge is OR-ed in after the clear so it survives a simultaneous W1C.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            irq_mask <= '0;
            edge_cap <= '0;
        end else begin
            if (wr_en && address == PIO_ADDR_IRQMASK) begin
                irq_mask <= writedata;
            end
            edge_cap <= (edge_cap & ~clr) | qual;
        end
    end

    always_comb begin
        readdata = '0;
        case (address)
            PIO_ADDR_DATA:    readdata = data;
            PIO_ADDR_IRQMASK: readdata = irq_mask;
            PIO_ADDR_EDGECAP: readdata = edge_cap;
            default:          readdata = '0;
        endcase
    end

    assign irq = |(edge_cap & irq_mask);

endmodule

// File: tb/tb_pio_edge_in.sv
// tb/tb_pio_edge_in.sv - scoreboard bench for pio_edge_in (any-edge and rise-only instances)
module tb_pio_edge_in;
    import pio_pkg::*;

    localparam int W = 4;
    localparam int D = 4;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         chipselect;
    logic         write_n;
    logic [1:0]   address;
    logic [W-1:0] writedata;
    logic [W-1:0] in_port;
    logic [W-1:0] rd_any;
    logic [W-1:0] rd_rise;
    logic         irq_any;
    logic         irq_rise;

    always #5 clk = ~clk;

    pio_edge_in #(.WIDTH(W), .DEBOUNCE_CYCLES(D), .EDGE_TYPE(2), .RESET_LEVEL(1)) dut_any (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(rd_any),
        .in_port(in_port), .irq(irq_any)
    );

    pio_edge_in #(.WIDTH(W), .DEBOUNCE_CYCLES(D), .EDGE_TYPE(0), .RESET_LEVEL(1)) dut_rise (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(rd_rise),
        .in_port(in_port), .irq(irq_rise)
    );

    typedef struct {
        string        tag;
        logic [W-1:0] rd0;
        logic [W-1:0] rd1;
        logic         irq0;
        logic         irq1;
    } exp_t;

    exp_t exp_q[$];
    int   compared   = 0;
    int   mismatched = 0;

    // Reference: pin seen two samples late; a level is accepted after D consecutive
    // late samples all disagree with the current accepted level.
    logic [W-1:0] m_d1, m_d2, m_stable, m_mask;
    logic [W-1:0] m_cap[2];
    logic [W-1:0] hist[$];
    bit           m_valid = 0;
    logic [W-1:0] pin_cur;

    task automatic model_edge(input logic rst, input logic cs, input logic wn,
                              input logic [1:0] a, input logic [W-1:0] wd,
                              input logic [W-1:0] pin);
        logic [W-1:0] s2, upd, nxt, rise_v, fall_v, clr;
        bit           all_diff;
        if (!rst) begin
            m_d1 = '1; m_d2 = '1; m_stable = '1; m_mask = '0;
            m_cap[0] = '0; m_cap[1] = '0;
            hist.delete();
            return;
        end
        s2 = m_d2;
        hist.push_back(s2);
        if (hist.size() > D) void'(hist.pop_front());
        upd = '0;
        nxt = m_stable;
        for (int b = 0; b < W; b++) begin
            all_diff = (hist.size() == D);
            for (int i = 0; i < hist.size(); i++)
                if (hist[i][b] == m_stable[b]) all_diff = 0;
            if (all_diff) begin
                upd[b] = 1'b1;
                nxt[b] = s2[b];
            end
        end
        rise_v = upd & nxt;
        fall_v = upd & ~nxt;
        clr = (cs && !wn && a == 2'd2) ? wd : '0;
        m_cap[0] = (m_cap[0] & ~clr) | rise_v | fall_v;
        m_cap[1] = (m_cap[1] & ~clr) | rise_v;
        if (cs && !wn && a == 2'd1) m_mask = wd;
        m_stable = nxt;
        m_d2 = m_d1;
        m_d1 = pin;
    endtask

    function automatic logic [W-1:0] exp_rd(input int j, input logic [1:0] a);
        case (a)
            2'd0:    return m_stable;
            2'd1:    return m_mask;
            2'd2:    return m_cap[j];
            default: return '0;
        endcase
    endfunction

    task automatic cyc(input logic rst, input logic cs, input logic wn,
                       input logic [1:0] a, input logic [W-1:0] wd, input string tag);
        exp_t e;
        reset_n = rst; chipselect = cs; write_n = wn;
        address = a; writedata = wd; in_port = pin_cur;
        if (m_valid) begin
            e.tag  = tag;
            e.rd0  = exp_rd(0, a);
            e.rd1  = exp_rd(1, a);
            e.irq0 = |(m_cap[0] & m_mask);
            e.irq1 = |(m_cap[1] & m_mask);
            exp_q.push_back(e);
        end
        @(posedge clk);
        model_edge(rst, cs, wn, a, wd, pin_cur);
        m_valid = 1;
        #1;
    endtask

    task automatic rd_cycle(input int n, input string tag);
        for (int i = 0; i < n; i++) cyc(1'b1, 1'b1, 1'b1, 2'(i % 3), '0, tag);
    endtask

    task automatic wr(input logic [1:0] a, input logic [W-1:0] d, input string tag);
        cyc(1'b1, 1'b1, 1'b0, a, d, tag);
    endtask

    task automatic check(input string tag, input string what,
                         input logic [W-1:0] got, input logic [W-1:0] want);
        compared++;
        if (got !== want) begin
            mismatched++;
            $display("FAIL %s %s: got %h expected %h", tag, what, got, want);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check(e.tag, "readdata_any",  rd_any,         e.rd0);
            check(e.tag, "readdata_rise", rd_rise,        e.rd1);
            check(e.tag, "irq_any",       W'(irq_any),    W'(e.irq0));
            check(e.tag, "irq_rise",      W'(irq_rise),   W'(e.irq1));
        end
    end

    initial begin
        pin_cur = 4'b0101;
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b1, 2'(i), '0, "reset");
        pin_cur = 4'hF;
        rd_cycle(4, "post_reset");

        wr(2'd1, 4'h1, "mask1");
        pin_cur[0] = 1'b0;
        rd_cycle(8, "fall0");
        wr(2'd2, 4'h1, "w1c0");
        rd_cycle(3, "after_clr");

        pin_cur[1] = 1'b0;
        rd_cycle(3, "glitch_low");
        pin_cur[1] = 1'b1;
        rd_cycle(8, "glitch");

        pin_cur[2] = 1'b0;
        for (int i = 0; i < 5; i++) cyc(1'b1, 1'b1, 1'b1, 2'd2, '0, "collide_wait");
        wr(2'd2, 4'h4, "collide");
        rd_cycle(3, "collide_after");

        wr(2'd1, 4'h0, "mask0");
        pin_cur[3] = 1'b0;
        rd_cycle(8, "cap3");
        wr(2'd1, 4'h8, "unmask3");
        rd_cycle(3, "irq3");

        pin_cur[0] = 1'b1;
        rd_cycle(8, "rise0");
        wr(2'd2, 4'hF, "clear_all");

        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 5) == 0) pin_cur[$urandom_range(0, W-1)] ^= 1'b1;
            cyc((i == 200 || i == 201) ? 1'b0 : 1'b1,
                1'($urandom_range(0, 1)),
                $urandom_range(0, 3) != 0,
                2'($urandom_range(0, 3)),
                W'($urandom_range(0, 15)),
                "random");
        end

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        #1;
        if (exp_q.size() > 0) begin
            compared++;
            mismatched++;
            $display("FAIL drain: %0d pending expectations, required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
